id_ex_operand_stage: RTL and testbench

//   ID/EX pipeline register plus EX-side operand forwarding for the MIPS32 core.

---
 rtl/id_ex_operand_if.sv | 63 ++++++
 rtl/id_ex_operand_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_if.sv
// Bus between decode/forwarding sources and the ID/EX operand stage.
// The master drives ID fields and the MEM/WB forward taps; the slave returns stall and the EX-side values.
interface id_ex_operand_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_rd_addr;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic [1:0]        id_op1_sel;
  logic              id_alu_src;
  logic [4:0]        id_alu_ctrl;
  logic              id_sign;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_fwd_data;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [DATA_W-1:0] wb_data;

  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [4:0]        alu_ctrl;
  logic              alu_sign;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [DATA_W-1:0] ex_store_data;

  modport master (
    output flush, id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr,
           id_rs_used, id_rt_used, id_rd_addr, id_imm, id_shamt, id_op1_sel,
           id_alu_src, id_alu_ctrl, id_sign, id_reg_write, id_mem_read,
           id_mem_write, mem_reg_write, mem_rd_addr, mem_fwd_data,
           wb_reg_write, wb_rd_addr, wb_data,
    input  stall, ex_valid, alu_in1, alu_in2, alu_ctrl, alu_sign, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
  );

  modport slave (
    input  flush, id_valid, id_rs_data, id_rt_data, id_rs_addr, id_rt_addr,
           id_rs_used, id_rt_used, id_rd_addr, id_imm, id_shamt, id_op1_sel,
           id_alu_src, id_alu_ctrl, id_sign, id_reg_write, id_mem_read,
           id_mem_write, mem_reg_write, mem_rd_addr, mem_fwd_data,
           wb_reg_write, wb_rd_addr, wb_data,
    output stall, ex_valid, alu_in1, alu_in2, alu_ctrl, alu_sign, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use stall.
// id_valid/ex_valid mark real instructions; no ready exists: stall holds ID for one cycle and a bubble enters EX.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           reset,
  id_ex_operand_if.slave bus
);
  localparam logic [4:0] CTRL_ZERO = 5'b11111;

  logic              ex_valid_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic [REG_AW-1:0] rd_addr_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        shamt_q;
  logic [1:0]        op1_sel_q;
  logic              alu_src_q;
  logic [4:0]        alu_ctrl_q;
  logic              sign_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              stall_c;
  logic              rs_hit;
  logic              rt_hit;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] in1_c;

  function automatic logic [DATA_W-1:0] forward(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] captured,
    input logic              m_we,
    input logic [REG_AW-1:0] m_addr,
    input logic [DATA_W-1:0] m_data,
    input logic              w_we,
    input logic [REG_AW-1:0] w_addr,
    input logic [DATA_W-1:0] w_data
  );
    logic [DATA_W-1:0] r;
    if (addr == '0)                           r = '0;
    else if (m_we && (m_addr == addr))        r = m_data;
    else if (w_we && (w_addr == addr))        r = w_data;
    else                                      r = captured;
    return r;
  endfunction

  always_comb begin
    rs_hit  = bus.id_rs_used && (bus.id_rs_addr == rd_addr_q);
    rt_hit  = bus.id_rt_used && (bus.id_rt_addr == rd_addr_q);
    stall_c = ex_valid_q && mem_read_q && (rd_addr_q != '0) && bus.id_valid &&
              !bus.flush && (rs_hit || rt_hit);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush || stall_c) begin
      ex_valid_q  <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      op1_sel_q   <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= CTRL_ZERO;
      sign_q      <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      ex_valid_q  <= bus.id_valid;
      rs_data_q   <= bus.id_rs_data;
      rt_data_q   <= bus.id_rt_data;
      rs_addr_q   <= bus.id_rs_addr;
      rt_addr_q   <= bus.id_rt_addr;
      rd_addr_q   <= bus.id_rd_addr;
      imm_q       <= bus.id_imm;
      shamt_q     <= bus.id_shamt;
      op1_sel_q   <= bus.id_op1_sel;
      alu_src_q   <= bus.id_alu_src;
      alu_ctrl_q  <= bus.id_alu_ctrl;
      sign_q      <= bus.id_sign;
      reg_write_q <= bus.id_reg_write && bus.id_valid;
      mem_read_q  <= bus.id_mem_read && bus.id_valid;
      mem_write_q <= bus.id_mem_write && bus.id_valid;
    end
  end

  always_comb begin
    fwd_rs = forward(rs_addr_q, rs_data_q, bus.mem_reg_write, bus.mem_rd_addr,
                     bus.mem_fwd_data, bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
    fwd_rt = forward(rt_addr_q, rt_data_q, bus.mem_reg_write, bus.mem_rd_addr,
                     bus.mem_fwd_data, bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
  end

  // The ALU reads shift amounts from input_1[10:6].
  always_comb begin
    in1_c = '0;
    case (op1_sel_q)
      2'd0:    in1_c = fwd_rs;
      2'd1:    in1_c[10:6] = shamt_q;
      2'd2:    in1_c[10:6] = fwd_rs[4:0];
      default: in1_c = '0;
    endcase
  end

  assign bus.stall         = stall_c;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_in1       = in1_c;
  assign bus.alu_in2       = alu_src_q ? imm_q : fwd_rt;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.alu_sign      = sign_q;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_store_data = fwd_rt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomized bench for id_ex_operand_stage against an instruction-level model.
module tb_id_ex_operand_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_ex_operand_if bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs_a, rt_a, rd, shamt, ctrl;
    logic [1:0]  sel;
    logic        src, sign, rw, mr, mw;
  } ex_t;

  ex_t m;

  function automatic ex_t bubble();
    ex_t b;
    b.v = 0; b.rs_d = 0; b.rt_d = 0; b.imm = 0; b.rs_a = 0; b.rt_a = 0;
    b.rd = 0; b.shamt = 0; b.ctrl = 5'b11111; b.sel = 0; b.src = 0;
    b.sign = 0; b.rw = 0; b.mr = 0; b.mw = 0;
    return b;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] cap);
    if (a == 0) return 32'h0;
    if (bus.mem_reg_write && bus.mem_rd_addr == a) return bus.mem_fwd_data;
    if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_data;
    return cap;
  endfunction

  function automatic logic ref_stall();
    logic uses;
    uses = (bus.id_rs_used && bus.id_rs_addr == m.rd) || (bus.id_rt_used && bus.id_rt_addr == m.rd);
    return m.v && m.mr && (m.rd != 0) && bus.id_valid && !bus.flush && uses;
  endfunction

  function automatic logic [31:0] ref_in1();
    logic [31:0] fr;
    logic [31:0] t;
    fr = ref_fwd(m.rs_a, m.rs_d);
    case (m.sel)
      2'd0: return fr;
      2'd1: begin t = {27'b0, m.shamt}; return t * 64; end
      2'd2: begin t = fr % 32; return t * 64; end
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_now();
    logic [31:0] frt;
    frt = ref_fwd(m.rt_a, m.rt_d);
    chk("stall", 32'(bus.stall), 32'(ref_stall()));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.v));
    chk("alu_in1", bus.alu_in1, ref_in1());
    chk("alu_in2", bus.alu_in2, m.src ? m.imm : frt);
    chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(m.ctrl));
    chk("alu_sign", 32'(bus.alu_sign), 32'(m.sign));
    chk("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(m.rd));
    chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
    chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
    chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
    chk("ex_store_data", bus.ex_store_data, frt);
  endtask

  task automatic tick();
    logic st;
    st = ref_stall();
    @(posedge clk);
    if (reset || bus.flush || st) m = bubble();
    else begin
      m.v = bus.id_valid; m.rs_d = bus.id_rs_data; m.rt_d = bus.id_rt_data;
      m.imm = bus.id_imm; m.rs_a = bus.id_rs_addr; m.rt_a = bus.id_rt_addr;
      m.rd = bus.id_rd_addr; m.shamt = bus.id_shamt; m.ctrl = bus.id_alu_ctrl;
      m.sel = bus.id_op1_sel; m.src = bus.id_alu_src; m.sign = bus.id_sign;
      m.rw = bus.id_reg_write & bus.id_valid;
      m.mr = bus.id_mem_read & bus.id_valid;
      m.mw = bus.id_mem_write & bus.id_valid;
    end
    #1;
  endtask

  task automatic clr();
    bus.flush = 0; bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
    bus.id_rd_addr = 0; bus.id_imm = 0; bus.id_shamt = 0; bus.id_op1_sel = 0;
    bus.id_alu_src = 0; bus.id_alu_ctrl = 0; bus.id_sign = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.mem_reg_write = 0;
    bus.mem_rd_addr = 0; bus.mem_fwd_data = 0; bus.wb_reg_write = 0;
    bus.wb_rd_addr = 0; bus.wb_data = 0;
  endtask

  task automatic id_rrr(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                        input logic [31:0] rtd, input logic [4:0] rd, input logic [4:0] ctrl);
    bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rs_data = rsd; bus.id_rs_used = 1;
    bus.id_rt_addr = rt; bus.id_rt_data = rtd; bus.id_rt_used = 1;
    bus.id_rd_addr = rd; bus.id_alu_ctrl = ctrl; bus.id_reg_write = 1;
  endtask

  task automatic id_lw(input logic [4:0] rd);
    clr();
    bus.id_valid = 1; bus.id_rd_addr = rd; bus.id_mem_read = 1; bus.id_reg_write = 1;
    bus.id_alu_src = 1; bus.id_imm = 32'h8; bus.id_alu_ctrl = 5'b00010;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    m = bubble();
    check_now();
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'h1f);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    reset = 0;

    // 1: add $3,$1,$2
    id_rrr(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'b00010);
    #1; check_now(); tick();
    clr(); #1; check_now();
    chk("add_in1", bus.alu_in1, 32'd5);
    chk("add_in2", bus.alu_in2, 32'd7);
    chk("add_ctrl", 32'(bus.alu_ctrl), 32'h02);
    chk("add_rd", 32'(bus.ex_rd_addr), 32'd3);

    // 2: forwarding priority, then no match
    bus.mem_reg_write = 1; bus.mem_rd_addr = 1; bus.mem_fwd_data = 32'hAA;
    bus.wb_reg_write = 1; bus.wb_rd_addr = 1; bus.wb_data = 32'hBB;
    #1; check_now(); chk("fwd_mem_prio", bus.alu_in1, 32'hAA);
    bus.wb_rd_addr = 2;
    #1; check_now(); chk("fwd_mem_rt_wb", bus.alu_in2, 32'hBB);
    bus.mem_rd_addr = 0; bus.wb_reg_write = 0;
    #1; check_now(); chk("fwd_mem_rd0", bus.alu_in1, 32'd5);
    clr();
    id_rrr(5'd0, 32'h55, 5'd2, 32'd9, 5'd7, 5'b00010);
    tick();
    clr(); bus.mem_reg_write = 1; bus.mem_rd_addr = 0; bus.mem_fwd_data = 32'hAA;
    #1; check_now(); chk("reg0_zero", bus.alu_in1, 32'h0);

    // 3: load-use
    id_lw(5'd4); tick();
    clr(); id_rrr(5'd4, 32'h0, 5'd6, 32'h66, 5'd5, 5'b00010);
    #1; check_now(); chk("lu_stall", 32'(bus.stall), 32'h1);
    tick();
    #1; check_now();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
    chk("lu_bubble_ctrl", 32'(bus.alu_ctrl), 32'h1f);
    chk("lu_stall_drop", 32'(bus.stall), 32'h0);
    tick();
    clr(); bus.wb_reg_write = 1; bus.wb_rd_addr = 4; bus.wb_data = 32'h1234;
    #1; check_now(); chk("lu_wb_fwd", bus.alu_in1, 32'h1234);

    // 4: shift operand packing
    clr(); bus.id_valid = 1; bus.id_shamt = 5'd3; bus.id_op1_sel = 2'd1; bus.id_rd_addr = 5'd8;
    tick(); clr(); #1; check_now(); chk("sll_in1", bus.alu_in1, 32'hC0);
    clr(); bus.id_valid = 1; bus.id_rs_addr = 5'd2; bus.id_rs_data = 32'h23; bus.id_rs_used = 1;
    bus.id_op1_sel = 2'd2; bus.id_rd_addr = 5'd8;
    tick(); clr(); #1; check_now(); chk("sllv_in1", bus.alu_in1, 32'hC0);

    // 5: flush beats load-use
    id_lw(5'd4); tick();
    clr(); id_rrr(5'd4, 32'h0, 5'd6, 32'h0, 5'd5, 5'b00010);
    bus.id_mem_write = 1; bus.flush = 1;
    #1; check_now(); chk("flush_stall", 32'(bus.stall), 32'h0);
    tick(); clr(); #1; check_now();
    chk("flush_valid", 32'(bus.ex_valid), 32'h0);
    chk("flush_rw", 32'(bus.ex_reg_write), 32'h0);
    chk("flush_mw", 32'(bus.ex_mem_write), 32'h0);

    // 6: reset during a stall
    id_lw(5'd4); tick();
    clr(); id_rrr(5'd4, 32'h0, 5'd6, 32'h0, 5'd5, 5'b00010);
    reset = 1; tick(); reset = 0;
    #1; check_now();
    chk("rst_mid_valid", 32'(bus.ex_valid), 32'h0);
    chk("rst_mid_stall", 32'(bus.stall), 32'h0);
    chk("rst_mid_ctrl", 32'(bus.alu_ctrl), 32'h1f);
    tick(); clr(); #1; check_now();
    chk("rst_resume", 32'(bus.ex_valid), 32'h1);

    // randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.id_valid = ($urandom_range(0, 4) != 0);
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
      bus.id_rs_addr = 5'($urandom_range(0, 7)); bus.id_rt_addr = 5'($urandom_range(0, 7));
      bus.id_rs_used = 1'($urandom); bus.id_rt_used = 1'($urandom);
      bus.id_rd_addr = 5'($urandom_range(0, 7)); bus.id_imm = $urandom;
      bus.id_shamt = 5'($urandom); bus.id_op1_sel = 2'($urandom);
      bus.id_alu_src = 1'($urandom); bus.id_alu_ctrl = 5'($urandom);
      bus.id_sign = 1'($urandom); bus.id_reg_write = 1'($urandom);
      bus.id_mem_read = ($urandom_range(0, 2) == 0); bus.id_mem_write = 1'($urandom);
      bus.mem_reg_write = 1'($urandom); bus.mem_rd_addr = 5'($urandom_range(0, 7));
      bus.mem_fwd_data = $urandom;
      bus.wb_reg_write = 1'($urandom); bus.wb_rd_addr = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      reset = ($urandom_range(0, 59) == 0);
      #1; check_now();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
